// File: rtl/irq_req_latch_pkg.sv
// Shared definitions for the interrupt request capture front end.
// Holds the FSM state encoding and the default sizing constants.
package irq_req_latch_pkg;

  // Default number of request lines. This is also the encoder input width.
  localparam int N_DEF = 4;

  // Default grant index width, equal to clog2(N_DEF).
  localparam int IDX_W_DEF = 2;

  // Fewest synchroniser flops that are still safe for asynchronous inputs.
  localparam int SYNC_MIN = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESENT = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

endpackage

// File: rtl/irq_req_latch_if.sv
// Handshake bundle between the request latch and its environment.
// Signals:
//   irq_in, irq_mask      : raw request lines and per-line mask
//   grant_idx, grant_ack  : grant index from the encoder and the accept pulse
//   ovf_clr               : clears the sticky overflow bits
//   req_vec, req_valid    : frozen request snapshot that drives encoder d_in
//   overflow, busy        : sticky overflow flags and FSM-not-idle flag
// The slave modport is the latch itself. The master modport is whoever drives it.
interface irq_req_latch_if
  import irq_req_latch_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int IDX_W = IDX_W_DEF
);
  logic [N-1:0]     irq_in;
  logic [N-1:0]     irq_mask;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_ack;
  logic             ovf_clr;
  logic [N-1:0]     req_vec;
  logic             req_valid;
  logic [N-1:0]     overflow;
  logic             busy;

  modport master (
    output irq_in, irq_mask, grant_idx, grant_ack, ovf_clr,
    input  req_vec, req_valid, overflow, busy
  );

  modport slave (
    input  irq_in, irq_mask, grant_idx, grant_ack, ovf_clr,
    output req_vec, req_valid, overflow, busy
  );
endinterface

// File: rtl/irq_req_latch_sync_edge_det.sv
// Single-bit synchroniser that feeds a rising-edge detector.
// Ports:
//   clk, rst_n : system clock and asynchronous active-low reset
//   i_d        : raw asynchronous input
//   o_sync     : synchronised level
//   o_rise     : one-cycle pulse when the synchronised level goes 0 -> 1
module irq_req_latch_sync_edge_det #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise
);

  logic [STAGES-1:0] r_sync;
  logic              r_sync_d;

  // Synchroniser shift chain, plus a delayed copy of the synchronised level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[STAGES-2:0], i_d};
      r_sync_d <= r_sync[STAGES-1];
    end
  end

  assign o_sync = r_sync[STAGES-1];
  assign o_rise = r_sync[STAGES-1] & ~r_sync_d;

endmodule

// File: rtl/irq_req_latch.sv
// Request capture front end that sits in front of the 4-bit priority encoder.
// Each raw line is synchronised and edge-detected, and the result is held as a sticky
// pending bit. When the FSM is idle, a masked snapshot of the pending bits is frozen
// into req_vec. An acknowledged grant clears only the bit that was granted.
// Ports:
//   clk, rst_n : system clock and asynchronous active-low reset
//   bus        : slave side of irq_req_latch_if (requests, grant handshake, status)
module irq_req_latch
  import irq_req_latch_pkg::*;
#(
  parameter int N           = N_DEF,
  parameter int IDX_W       = IDX_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int LEVEL_MODE  = 0
) (
  input logic           clk,
  input logic           rst_n,
  irq_req_latch_if.slave bus
);

  // Shallower synchronisers are not safe, so the depth is clamped to the minimum.
  localparam int SYNC_EFF = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;

  state_t           r_state;
  logic [N-1:0]     r_pending;
  logic [N-1:0]     r_overflow;
  logic [N-1:0]     r_req_vec;
  logic             r_req_valid;
  logic             r_busy;

  logic [N-1:0]     w_sync;
  logic [N-1:0]     w_rise;
  logic [N-1:0]     w_set;
  logic [N-1:0]     w_clr;
  logic [N-1:0]     w_unmasked;
  logic [IDX_W-1:0] w_idx;
  logic             w_ack_hit;

  for (genvar g = 0; g < N; g++) begin : g_sync
    irq_req_latch_sync_edge_det #(
      .STAGES(SYNC_EFF)
    ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_d    (bus.irq_in[g]),
      .o_sync (w_sync[g]),
      .o_rise (w_rise[g])
    );
  end

  assign w_idx      = bus.grant_idx;
  assign w_set      = (LEVEL_MODE != 0) ? w_sync : w_rise;
  assign w_unmasked = r_pending & ~bus.irq_mask;
  // Only a grant that names a bit of the frozen snapshot is accepted.
  assign w_ack_hit  = (r_state == ST_PRESENT) && bus.grant_ack && r_req_vec[w_idx];

  // One-hot clear mask for the granted pending bit
  always_comb begin
    w_clr = '0;
    if (w_ack_hit) begin
      w_clr[w_idx] = 1'b1;
    end else begin
      w_clr = '0;
    end
  end

  // Sticky pending and overflow bits. A set beats a clear, and ovf_clr beats a new overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_overflow <= '0;
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
      if (bus.ovf_clr) begin
        r_overflow <= '0;
      end else begin
        r_overflow <= r_overflow | (w_rise & r_pending & ~w_clr);
      end
    end
  end

  // Presentation FSM with registered snapshot, valid and busy outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_req_vec   <= '0;
      r_req_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_unmasked) begin
            r_state     <= ST_PRESENT;
            r_req_vec   <= w_unmasked;
            r_req_valid <= 1'b1;
            r_busy      <= 1'b1;
          end else begin
            r_state     <= ST_IDLE;
            r_req_vec   <= '0;
            r_req_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        ST_PRESENT: begin
          if (w_ack_hit) begin
            r_state     <= ST_HOLDOFF;
            r_req_vec   <= '0;
            r_req_valid <= 1'b0;
            r_busy      <= 1'b1;
          end else begin
            // The snapshot stays frozen. New edges and mask changes only affect pending.
            r_state     <= ST_PRESENT;
            r_req_vec   <= r_req_vec;
            r_req_valid <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        ST_HOLDOFF: begin
          // One dead cycle lets the encoder output settle before the next snapshot.
          r_state     <= ST_IDLE;
          r_req_vec   <= '0;
          r_req_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          r_req_vec   <= '0;
          r_req_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_vec   = r_req_vec;
  assign bus.req_valid = r_req_valid;
  assign bus.overflow  = r_overflow;
  assign bus.busy      = r_busy;

endmodule

// File: doc/irq_req_latch.md
Name: irq_req_latch

Overview:
- Request-capture front end that sits directly upstream of the 4-bit priority encoder.
- Synchronises raw request lines, detects rising edges and holds them as sticky pending bits, then applies the mask.
- Presents a frozen request vector to the encoder's d_in with a valid flag.
- Consumes the encoder's d_out as the grant index; on acknowledge, clears only the granted pending bit.

Parameters:
- N, 4, number of request lines; must equal the encoder input width.
- IDX_W, 2, grant index width; equals clog2(N).
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser; minimum 2.
- LEVEL_MODE, 0, 0 = rising-edge capture, 1 = level capture (pending follows the synchronised level while set).

Ports:
- clk  in  1  single system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- irq_in  in  N  raw asynchronous request lines.
- irq_mask  in  N  1 = line masked; masked bits still latch as pending but are not presented.
- grant_idx  in  IDX_W  index from the downstream encoder (d_out).
- grant_ack  in  1  one-cycle pulse: consumer accepted grant_idx.
- ovf_clr  in  1  clears all overflow bits.
- req_vec  out  N  snapshot of pending & ~mask; drives encoder d_in.
- req_valid  out  1  req_vec holds a non-zero request.
- overflow  out  N  sticky; an edge arrived on a line that was already pending.
- busy  out  1  FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): synchroniser, edge registers, pending, req_vec, overflow, req_valid and busy all 0; FSM goes to IDLE. Reset asserted mid-handshake discards all pending requests.
- Synchroniser: SYNC_STAGES-deep per bit. Edge detect = sync & ~sync_d.
- Pending set: an edge (or, when LEVEL_MODE=1, the synchronised level) sets pending[i] on the next clock.
- Pending clear: grant_ack in PRESENT with snapshot[grant_idx]=1 clears pending[grant_idx].
- Set and clear of the same bit in the same cycle: set wins.
- Overflow: an edge on a bit whose pending is already 1 sets overflow[i], unless that same cycle also clears the bit. ovf_clr has priority over a new overflow set in the same cycle.
- FSM states: IDLE, PRESENT, HOLDOFF.
  - IDLE: req_valid=0 and req_vec=0. If (pending & ~irq_mask) != 0, register the snapshot into req_vec and go to PRESENT.
  - PRESENT: req_valid=1; req_vec is frozen. New edges and mask changes affect pending only, not the snapshot.
    - grant_ack with snapshot[grant_idx]=1: clear that bit, go to HOLDOFF.
    - grant_ack with snapshot[grant_idx]=0: ignored; stay in PRESENT.
  - HOLDOFF: req_valid=0 for exactly one cycle so the encoder output settles, then go to IDLE.
- Latency:
  - irq_in rising, sampled at edge k: pending set at edge k+SYNC_STAGES; req_valid high after edge k+SYNC_STAGES+1.
  - grant_ack at edge j: req_valid low after j; earliest re-assert after edge j+2.
- Masking a bit while in PRESENT does not withdraw it from the snapshot. Unmasking a bit that is pending exposes it on the next IDLE entry.
- grant_ack in IDLE or HOLDOFF: ignored.
- busy = (state != IDLE).

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, PRESENT=2'd1, HOLDOFF=2'd2), default N/IDX_W constants, SYNC_STAGES minimum.
- One natural sub-module: sync_edge_det, parameterised per-bit synchroniser plus rising-edge detector, instantiated N wide. The FSM and pending logic stay in the top module.

Test Plan:
- Reset, then pulse irq_in=4'b0100 for 3 cycles -> req_vec=4'b0100 and req_valid=1 exactly SYNC_STAGES+1 edges after sampling. After grant_idx=2 with grant_ack -> pending=0, req_valid low one cycle, then FSM in IDLE.
- Pulse irq_in=4'b1001 simultaneously -> req_vec=4'b1001. Ack grant_idx=3 -> after HOLDOFF, req_vec=4'b0001 and req_valid=1. Ack grant_idx=0 -> idle, busy=0.
- irq_mask=4'b0010 with pulse on bit 1 -> req_valid stays 0 for 10 cycles. Clear mask -> req_vec=4'b0010 two edges later.
- In PRESENT with snapshot 4'b0001, pulse bit 3 -> req_vec stays 4'b0001. After ack of 0 -> req_vec=4'b1000.
- Second edge on pending bit 2 -> overflow=4'b0100. Pulse ovf_clr -> overflow=0.
- grant_ack with grant_idx=1 against snapshot 4'b0100 -> ignored; state PRESENT, pending unchanged. Assert rst_n low mid-PRESENT -> all outputs 0 immediately, without waiting for a clock edge.
